// File: rtl/issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : issue_arbiter
//  Purpose  : Round-robin arbiter sharing the single ALU issue port among N
//             execution-buffer requesters, with one registered output stage
//             under a valid/ready handshake. A ROB flush clears the stage.
//  Options  : define ISSUE_ARB_PERF_EN to build the saturating issued/stall
//             performance counters; otherwise both counter outputs read 0.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_arbiter #(
  parameter int N     = 4,
  parameter int W     = 48,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_grant,
  output logic                 issue_valid,
  output logic [W-1:0]         issue_data,
  output logic [$clog2(N)-1:0] issue_src,
  input  logic                 issue_ready,
  output logic [CNT_W-1:0]     issued_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W:0] C_N_EXT = (IDX_W+1)'(N);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_issue_valid;
  logic [W-1:0]     r_issue_data;
  logic [IDX_W-1:0] r_issue_src;

  logic             w_load_en;
  logic             w_found;
  logic             w_grant_en;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_next_sum;
  logic [IDX_W-1:0] w_next_ptr;

  // The stage may accept a new entry when empty or when it drains this cycle.
  assign w_load_en  = ~r_issue_valid | issue_ready;
  assign w_grant_en = w_found & w_load_en & ~flush & ~rst;

  // Search from rr_ptr upward; explicit modulo since N need not be a power of 2.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= C_N_EXT) w_sum = w_sum - C_N_EXT;
      if (!w_found && req_valid[w_sum[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[IDX_W-1:0];
      end
    end
  end

  // Pointer moves to just past the winner, wrapping N-1 -> 0.
  always_comb begin
    w_next_sum = {1'b0, w_winner} + (IDX_W+1)'(1);
    w_next_ptr = (w_next_sum == C_N_EXT) ? '0 : w_next_sum[IDX_W-1:0];
  end

  // One-hot grant to the winner, or zero when nothing may be loaded.
  always_comb begin
    req_grant = '0;
    for (int i = 0; i < N; i++) begin
      req_grant[i] = w_grant_en && (w_winner == IDX_W'(i));
    end
  end

  // Output stage and round-robin pointer; flush wins over both load and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_valid <= 1'b0;
      r_issue_data  <= '0;
      r_issue_src   <= '0;
      r_rr_ptr      <= '0;
    end else if (w_grant_en) begin
      r_issue_valid <= 1'b1;
      r_issue_data  <= req_data[w_winner*W +: W];
      r_issue_src   <= w_winner;
      r_rr_ptr      <= w_next_ptr;
    end else if (flush || w_load_en) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_data  = r_issue_data;
  assign issue_src   = r_issue_src;

`ifdef ISSUE_ARB_PERF_EN
  logic [CNT_W-1:0] r_issued_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating counters of accepted issues and back-pressured cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (r_issue_valid && issue_ready && !(&r_issued_cnt))
        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      if (r_issue_valid && !issue_ready && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign issued_cnt = r_issued_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign issued_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_arbiter
//  Purpose  : Self-checking bench for issue_arbiter (N=4, W=48, CNT_W=4)
//             against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_arbiter;

  localparam int N = 4;
  localparam int W = 48;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_grant;
  logic             issue_valid;
  logic [W-1:0]     issue_data;
  logic [1:0]       issue_src;
  logic             issue_ready = 1'b0;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] stall_cnt;

  issue_arbiter #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_grant(req_grant),
    .issue_valid(issue_valid), .issue_data(issue_data), .issue_src(issue_src),
    .issue_ready(issue_ready), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_src, m_ptr, m_issued, m_stall;
  logic [W-1:0] pay [N];
  logic         cur_rdy, cur_fl;
  int           exp_win;
  logic [N-1:0] exp_grant;

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_issued = 0; m_stall = 0;
  endtask

  // Drive one cycle of inputs (called 1 time unit after a posedge) and derive the expected grant.
  task automatic apply(input logic [N-1:0] v, input logic rdy, input logic fl);
    for (int i = 0; i < N; i++) begin
      pay[i] = W'({$urandom(), $urandom()});
      req_data[i*W +: W] = pay[i];
    end
    req_valid = v; issue_ready = rdy; flush = fl;
    cur_rdy = rdy; cur_fl = fl;
    exp_win = -1;
    if ((!m_valid || rdy) && !fl)
      for (int k = 0; k < N; k++)
        if (exp_win < 0 && v[(m_ptr + k) % N]) exp_win = (m_ptr + k) % N;
    exp_grant = (exp_win >= 0) ? N'(1 << exp_win) : '0;
  endtask

  // Clock edge: update model the way the specification describes, then step off the edge.
  task automatic advance();
    @(posedge clk);
`ifdef ISSUE_ARB_PERF_EN
    if (m_valid && cur_rdy && m_issued < 15) m_issued++;
    if (m_valid && !cur_rdy && m_stall < 15) m_stall++;
`endif
    if (exp_win >= 0) begin
      m_valid = 1'b1; m_data = pay[exp_win]; m_src = exp_win; m_ptr = (exp_win + 1) % N;
    end else if (cur_fl || !m_valid || cur_rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", issue_valid); end
    total++; if (issue_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", issue_data); end
    total++; if (issue_src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", issue_src); end
    total++; if (req_grant !== '0) begin bad++; $display("FAIL reset_grant got=%b exp=0", req_grant); end
    total++; if (issued_cnt !== '0 || stall_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", issued_cnt, stall_cnt); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      apply(4'b1111, 1'b1, 1'b0); #3;
      total++; if (req_grant !== exp_grant || req_grant !== N'(1 << (c % N))) begin
        bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_grant, N'(1 << (c % N))); end
      total++; if (issue_valid !== (c > 0)) begin bad++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", c, issue_valid, c > 0); end
      if (c > 0) begin
        total++; if (issue_src !== 2'((c - 1) % N) || issue_data !== m_data) begin
          bad++; $display("FAIL rr_src cyc=%0d got=%0d/%h exp=%0d/%h", c, issue_src, issue_data, (c - 1) % N, m_data); end
      end
      advance();
    end
  endtask

  task automatic test_sparse_wrap();
    logic [N-1:0] vs [4];
    logic [N-1:0] gs [4];
    vs[0] = 4'b0100; vs[1] = 4'b0010; vs[2] = 4'b1001; vs[3] = 4'b1111;
    gs[0] = 4'b0100; gs[1] = 4'b0010; gs[2] = 4'b1000; gs[3] = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      apply(vs[c], 1'b1, 1'b0); #3;
      total++; if (req_grant !== exp_grant || req_grant !== gs[c]) begin
        bad++; $display("FAIL sparse_grant step=%0d got=%b exp=%b", c, req_grant, gs[c]); end
      advance();
    end
    total++; if (issue_valid !== 1'b1 || issue_src !== 2'd0 || issue_data !== m_data) begin
      bad++; $display("FAIL sparse_out got=%b/%0d/%h exp=1/0/%h", issue_valid, issue_src, issue_data, m_data); end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held;
    held = issue_data;
    for (int c = 0; c < 3; c++) begin
      apply(4'b0100, 1'b0, 1'b0); #3;
      total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL bp_grant cyc=%0d got=%b exp=0000", c, req_grant); end
      total++; if (issue_valid !== 1'b1 || issue_data !== held) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", c, issue_valid, issue_data, held); end
      total++; if (stall_cnt !== CNT_W'(m_stall)) begin bad++; $display("FAIL bp_stall cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
      advance();
    end
    apply(4'b0100, 1'b1, 1'b0); #3;
    total++; if (req_grant !== 4'b0100) begin bad++; $display("FAIL bp_release got=%b exp=0100", req_grant); end
    held = pay[2];
    advance(); #3;
    total++; if (issue_valid !== 1'b1 || issue_src !== 2'd2 || issue_data !== held) begin
      bad++; $display("FAIL bp_payload got=%b/%0d/%h exp=1/2/%h", issue_valid, issue_src, issue_data, held); end
    total++; if (stall_cnt !== CNT_W'(m_stall)) begin bad++; $display("FAIL bp_stall_end got=%0d exp=%0d", stall_cnt, m_stall); end
    #1 ;
  endtask

  task automatic test_flush();
    int ptr_before;
    ptr_before = m_ptr;
    apply(4'b0001, 1'b0, 1'b1); #3;
    total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL flush_grant got=%b exp=0000", req_grant); end
    advance();
    apply(4'b0001, 1'b0, 1'b0); #3;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", issue_valid); end
    total++; if (req_grant !== 4'b0001 || m_ptr != ptr_before) begin bad++; $display("FAIL flush_regrant got=%b exp=0001", req_grant); end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply(N'($urandom()), ($urandom() % 4) != 0, ($urandom() % 16) == 0); #3;
      total++; if (req_grant !== exp_grant) begin bad++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, req_grant, exp_grant); end
      total++; if (issue_valid !== m_valid || issue_data !== m_data || issue_src !== 2'(m_src)) begin
        bad++; $display("FAIL rand_stage cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, issue_valid, issue_src, issue_data, m_valid, m_src, m_data); end
      total++; if (issued_cnt !== CNT_W'(m_issued) || stall_cnt !== CNT_W'(m_stall)) begin
        bad++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, issued_cnt, stall_cnt, m_issued, m_stall); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6 && !(m_valid && m_ptr == 2); c++) begin
      apply(4'b1111, 1'b1, 1'b0); advance();
    end
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", issue_valid); end
    apply(4'b1111, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b0 || issue_src !== 2'd0 || issue_data !== '0) begin
      bad++; $display("FAIL rstmid_stage got=%b/%0d/%h exp=0/0/0", issue_valid, issue_src, issue_data); end
    total++; if (req_grant !== 4'b0000) begin bad++; $display("FAIL rstmid_grant got=%b exp=0000", req_grant); end
    total++; if (issued_cnt !== '0 || stall_cnt !== '0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", issued_cnt, stall_cnt); end
    req_valid = '0; issue_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    apply(4'b1111, 1'b1, 1'b0); #3;
    total++; if (req_grant !== 4'b0001) begin bad++; $display("FAIL rstmid_first got=%b exp=0001", req_grant); end
    advance();
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 22; c++) begin
      apply(4'b1111, 1'b1, 1'b0); #3;
      total++; if (issued_cnt !== CNT_W'(m_issued)) begin bad++; $display("FAIL sat_step cyc=%0d got=%0d exp=%0d", c, issued_cnt, m_issued); end
      advance();
    end
`ifdef ISSUE_ARB_PERF_EN
    total++; if (issued_cnt !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", issued_cnt); end
`else
    total++; if (issued_cnt !== 4'd0) begin bad++; $display("FAIL sat_final got=%0d exp=0", issued_cnt); end
`endif
  endtask

  initial begin
    model_reset();
    cur_rdy = 1'b0; cur_fl = 1'b0; exp_win = -1; exp_grant = '0;
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_back_pressure();
    test_flush();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
